// File: rtl/i2c_target.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection, write bytes to rx_data,
// read bytes requested via tx_req and shifted out MSB-first on an open-drain split SDA.
module i2c_target #(
  parameter logic [6:0]  ADDR        = 7'h55,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       rw
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StWaitStop
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [7:0] sreg_q, sreg_d, rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       done_q, done_d;
  logic       sda_out_q, sda_out_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       busy_q, busy_d, rw_q, rw_d;
  logic [7:0] shift_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = sda_d & ~sda_s & scl_s;
  assign stop_det  = ~sda_d & sda_s & scl_s;
  assign shift_in  = {sreg_q[6:0], sda_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // done_q marks "byte (or read ACK) complete, act on the next scl_fall"
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = StAddr;
    end else if (stop_det) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise && bit_cnt_q == 3'd7 && shift_in[7:1] != ADDR) state_d = StWaitStop;
          else if (scl_fall && done_q) state_d = StAddrAck;
        end
        StAddrAck, StWrAck: if (scl_fall) state_d = rw_q ? StRdData : StWrData;
        StWrData:   if (scl_fall && done_q) state_d = StWrAck;
        StRdData:   if (scl_fall && done_q) state_d = StRdAck;
        StRdAck: begin
          if (scl_rise && sda_s) state_d = StWaitStop;
          else if (scl_fall && done_q) state_d = StRdData;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sreg_d     = tx_req_q ? tx_data : sreg_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    done_d     = done_q;
    sda_out_d  = sda_out_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (start_det || stop_det) begin
      bit_cnt_d = 3'd0;
      done_d    = 1'b0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StWrData, StRdData: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (state_q != StRdData) sreg_d = shift_in;
            if (bit_cnt_q == 3'd7) begin
              done_d = 1'b1;
              if (state_q == StAddr) begin
                if (shift_in[7:1] == ADDR) begin
                  rw_d     = shift_in[0];
                  busy_d   = 1'b1;
                  tx_req_d = shift_in[0];
                end else begin
                  done_d = 1'b0;
                end
              end
              if (state_q == StWrData) begin
                rx_data_d  = shift_in;
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall) begin
            if (done_q) begin
              done_d    = 1'b0;
              sda_out_d = (state_q == StRdData);
            end else if (state_q == StRdData) begin
              sreg_d    = {sreg_q[6:0], 1'b0};
              sda_out_d = sreg_q[6];
            end
          end
        end
        StAddrAck, StWrAck: if (scl_fall) sda_out_d = rw_q ? sreg_q[7] : 1'b1;
        StRdAck: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              busy_d = 1'b0;
            end
          end else if (scl_fall && done_q) begin
            done_d    = 1'b0;
            sda_out_d = sreg_q[7];
          end
        end
        default: sda_out_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q     <= 8'h00;
      rx_data_q  <= 8'h00;
      bit_cnt_q  <= 3'd0;
      done_q     <= 1'b0;
      sda_out_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
      sda_out_q  <= sda_out_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  assign sda_out  = sda_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign rw       = rw_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master on a wired-AND SDA, table of write transfers
// plus hand-written read, repeated START, abort and mid-transfer reset sequences.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_out;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, rw;

  assign sda_bus = sda_m & sda_out;

  i2c_target #(.ADDR(7'h55), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_bus), .sda_out(sda_out),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req),
    .busy(busy), .rw(rw)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rxv_cnt = 0;
  int txr_cnt = 0;
  int low_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (tx_req) txr_cnt++;
    if (!sda_out) low_cnt++;
  end

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_rx;
  } wr_vec_t;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    tick(6); sda_m = 1'b1; tick(2); scl = 1'b1; tick(4); sda_m = 1'b0; tick(4); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(6); sda_m = 1'b0; tick(2); scl = 1'b1; tick(4); sda_m = 1'b1; tick(8);
  endtask

  task automatic clock_bit(input logic b, output logic smp);
    tick(6); sda_m = b; tick(2); scl = 1'b1; tick(4); smp = sda_bus; tick(4); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] got);
    logic s;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      got = {got[6:0], s};
    end
    tx_data = next_tx;
    clock_bit(m_ack, s);
  endtask

  initial begin
    wr_vec_t    vecs[4];
    logic       a1, a2;
    logic [7:0] got;
    int         rxv0, txr0, low0;

    vecs[0] = '{addr_byte: 8'hAA, data: 8'hAA, exp_ack: 1'b1, exp_rx: 8'hAA};
    vecs[1] = '{addr_byte: 8'h54, data: 8'h12, exp_ack: 1'b0, exp_rx: 8'hAA};
    vecs[2] = '{addr_byte: 8'hAA, data: 8'h3C, exp_ack: 1'b1, exp_rx: 8'h3C};
    vecs[3] = '{addr_byte: 8'hAA, data: 8'h00, exp_ack: 1'b1, exp_rx: 8'h00};

    tick(3);
    chk("reset sda_out", sda_out, 1);
    chk("reset rx_data", rx_data, 0);
    chk("reset pulses", {rx_valid, tx_req}, 0);
    chk("reset busy/rw", {busy, rw}, 0);
    rst = 1'b1;
    tick(4);

    for (int v = 0; v < 4; v++) begin
      rxv0 = rxv_cnt; low0 = low_cnt;
      bus_start();
      write_byte(vecs[v].addr_byte, a1);
      chk($sformatf("v%0d addr ack", v), a1, vecs[v].exp_ack);
      chk($sformatf("v%0d busy", v), busy, vecs[v].exp_ack);
      write_byte(vecs[v].data, a2);
      chk($sformatf("v%0d data ack", v), a2, vecs[v].exp_ack);
      bus_stop();
      chk($sformatf("v%0d rx_valid pulses", v), rxv_cnt - rxv0, vecs[v].exp_ack);
      chk($sformatf("v%0d rx_data", v), rx_data, vecs[v].exp_rx);
      chk($sformatf("v%0d busy after stop", v), busy, 0);
      chk($sformatf("v%0d sda driven", v), (low_cnt != low0), vecs[v].exp_ack);
      if (vecs[v].exp_ack) chk($sformatf("v%0d rw", v), rw, 0);
    end

    // Read: ACK first byte, NACK second
    txr0 = txr_cnt;
    tx_data = 8'hCC;
    bus_start();
    write_byte(8'hAB, a1);
    chk("rd addr ack", a1, 1);
    chk("rd rw", rw, 1);
    read_byte(1'b0, 8'hDD, got);
    chk("rd byte0", got, 8'hCC);
    read_byte(1'b1, 8'h00, got);
    chk("rd byte1", got, 8'hDD);
    tick(10);
    chk("rd sda released after nack", sda_out, 1);
    chk("rd busy after nack", busy, 0);
    bus_stop();
    chk("rd tx_req pulses", txr_cnt - txr0, 2);
    chk("rd sda after stop", sda_out, 1);

    // Repeated START: write then read without STOP
    rxv0 = rxv_cnt;
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'hAA, a1);
    write_byte(8'h01, a2);
    chk("rs write acks", {a1, a2}, 2'b11);
    chk("rs rw before", rw, 0);
    txr0 = txr_cnt;
    bus_start();
    write_byte(8'hAB, a1);
    chk("rs read addr ack", a1, 1);
    chk("rs rw after", rw, 1);
    chk("rs tx_req", txr_cnt - txr0, 1);
    chk("rs rx_data", rx_data, 8'h01);
    read_byte(1'b1, 8'h00, got);
    chk("rs read byte", got, 8'h5A);
    bus_stop();
    chk("rs rx_valid pulses", rxv_cnt - rxv0, 1);

    // Abort after 4 data bits
    rxv0 = rxv_cnt;
    bus_start();
    write_byte(8'hAA, a1);
    chk("ab addr ack", a1, 1);
    clock_bit(1'b1, a2); clock_bit(1'b0, a2); clock_bit(1'b1, a2); clock_bit(1'b0, a2);
    bus_stop();
    chk("ab sda_out", sda_out, 1);
    chk("ab rx_valid", rxv_cnt - rxv0, 0);
    chk("ab rx_data kept", rx_data, 8'h01);
    chk("ab busy", busy, 0);

    // Reset while the target holds the address ACK low
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'hAA >> i) & 8'h01) != 0, a2);
    tick(6);
    chk("rst ack driven", sda_out, 0);
    #2 rst = 1'b0;
    #1 chk("rst async release", sda_out, 1);
    chk("rst busy", busy, 0);
    scl = 1'b1; sda_m = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(4);
    rxv0 = rxv_cnt;
    bus_start();
    write_byte(8'hAA, a1);
    write_byte(8'hC3, a2);
    bus_stop();
    chk("post-rst acks", {a1, a2}, 2'b11);
    chk("post-rst rx_data", rx_data, 8'hC3);
    chk("post-rst rx_valid", rxv_cnt - rxv0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
